datamemory_sync: RTL
====================

Name: datamemory_sync

Overview:
Parametrised synchronous successor to the single-cycle data memory, for the CNN datapath and the pipelined core.
- Registered read with a valid strobe.
- Per-byte write enables.
- Hardware zero-fill after reset.
- Out-of-range address detection.
- Sits between the load/store stage (or feature-map buffer controller) and on-chip block RAM.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8
ADDR_W, 10, word-address width
DEPTH, 1024, number of words; must satisfy 1 <= DEPTH <= 2^ADDR_W
NB, DATA_W/8, number of byte lanes (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
address  input  ADDR_W  word address
writedata  input  DATA_W  write data
byteen  input  NB  byte-lane write enables; bit i covers writedata[8i+7:8i]
memread  input  1  read request, sampled at posedge
memwrite  input  1  write request, sampled at posedge
readdata  output  DATA_W  registered read data
readvalid  output  1  high for one cycle when readdata holds a completed read
busy  output  1  high while zero-fill is in progress; requests are ignored
addrerr  output  1  one-cycle pulse when an accepted request has address >= DEPTH

Behaviour:
- All state is updated only on the posedge of clk. Reset is synchronous: rst_n is sampled low at a posedge.
- Reset values (any posedge with rst_n=0):
  - readdata=0, readvalid=0, addrerr=0, busy=1
  - state=CLEAR, clear pointer=0
  - Memory contents are not touched during the reset cycle.
- States:
  - CLEAR: each posedge writes 0 to mem[ptr] and increments ptr. The posedge that writes ptr=DEPTH-1 moves to READY and clears busy. busy stays high for exactly DEPTH cycles after rst_n goes high. readvalid and addrerr are held 0. memread/memwrite are ignored.
  - READY: serves requests. It is left only by reset.
- Reset asserted mid-CLEAR or mid-READY restarts CLEAR from ptr=0.
- Write (READY, memwrite=1, address<DEPTH): each lane i with byteen[i]=1 takes writedata lane i at this posedge. Lanes with byteen[i]=0 are unchanged. byteen=0 is a no-op write and raises no error.
- Read (READY, memread=1, address<DEPTH): at this posedge readdata<=mem[address] and readvalid<=1, so latency is 1 cycle. If memread=0, readvalid<=0 and readdata holds its last value.
- Simultaneous read and write to the same address is write-first: readdata returns the merged word, i.e. old bytes where byteen=0 and new bytes where byteen=1.
- Out of range (READY, memread or memwrite, address>=DEPTH):
  - no memory change
  - addrerr<=1 for one cycle
  - if memread: readdata<=0, readvalid<=1
  - addrerr<=0 on every other cycle
- Back-to-back reads every cycle give readvalid continuously high with one new word per cycle.
- No X on outputs after the first reset cycle.

Test Plan:
1. DEPTH=16. Hold rst_n=0 for 2 cycles, then release -> busy=1 for exactly 16 cycles, then 0. Reads of addresses 0..15 return 0, and readvalid is high 1 cycle after each request.
2. Write, then read back each of these pairs (byteen=4'hF):
   - addr 0: 0xC00000F0
   - addr 1: 0x00000F00
   - addr 2: 0x0000F000
   - addr 3: 0x000F0000
   - addr 0x145: 0xF0000F00
   - addr 0x305: 0x90600F00
   - addr 0x2E0: 0xC7030F00
   -> each read returns the written value with a 1-cycle latency.
3. Byte lanes: write 0xAABBCCDD to addr 5 with byteen=F, then 0x11223344 with byteen=4'b0101 -> read returns 0xAA22CC44.
4. Same-cycle memread+memwrite to addr 7 (old 0x0, write 0x12345678, byteen=4'b0011) -> readdata=0x00005678 on the next cycle.
5. DEPTH=1000, read addr 1000 and write addr 1023 -> addrerr pulses 1 cycle for each, the read returns 0 with readvalid=1, and addr 999 is unchanged.
6. Assert rst_n=0 on cycle 5 of CLEAR (DEPTH=16) and on a READY cycle with memwrite=1 -> the write is not performed, busy restarts for 16 cycles, and readvalid=0 during reset and CLEAR.

Source files
------------

// File: rtl/datamemory_sync.sv
// Synchronous data memory: registered read with valid strobe, byte-lane
// writes, hardware zero-fill after reset and out-of-range detection.
module datamemory_sync #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] writedata,
    input  logic [DATA_W/8-1:0] byteen,
    input  logic              memread,
    input  logic              memwrite,
    output logic [DATA_W-1:0] readdata,
    output logic              readvalid,
    output logic              busy,
    output logic              addrerr
);

    localparam int NB = DATA_W / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic readvalid_q, readvalid_d;
    logic busy_q, busy_d;
    logic addrerr_q, addrerr_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic [PW-1:0]     idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;
    logic              mem_we;
    logic [PW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_range = ({1'b0, address} < DEPTH_L);
    assign idx      = address[PW-1:0];
    assign rd_word  = in_range ? mem[idx] : '0;

    // Write-first view of the addressed word: a same-cycle read sees the merge.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < NB; i++) begin
            if (memwrite && byteen[i]) begin
                merged[8*i +: 8] = writedata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        readdata_d  = readdata_q;
        readvalid_d = 1'b0;
        busy_d      = busy_q;
        addrerr_d   = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = '0;
        if (!rst_n) begin
            state_d    = CLEAR;
            ptr_d      = '0;
            readdata_d = '0;
            busy_d     = 1'b1;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    if (ptr_q == LAST_PTR) begin
                        state_d = READY;
                        busy_d  = 1'b0;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
                READY: begin
                    busy_d    = 1'b0;
                    addrerr_d = (memread || memwrite) && !in_range;
                    if (memwrite && in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = idx;
                        mem_wdata = merged;
                    end
                    if (memread) begin
                        readvalid_d = 1'b1;
                        readdata_d  = in_range ? merged : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q     <= state_d;
        ptr_q       <= ptr_d;
        readdata_q  <= readdata_d;
        readvalid_q <= readvalid_d;
        busy_q      <= busy_d;
        addrerr_q   <= addrerr_d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign readdata  = readdata_q;
    assign readvalid = readvalid_q;
    assign busy      = busy_q;
    assign addrerr   = addrerr_q;

endmodule
